// File: rtl/load_align_unit.sv
// MEM-stage load engine: word-aligned read over req/ack, then extract/extend/merge into Dout.
// Done arrives two cycles after Start when the ack is immediate; Busy stalls the pipe while the read is outstanding.
module load_align_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] Adr,
  input  logic [2:0]  LdCtrl,
  input  logic [31:0] RtOld,
  output logic        MemReq,
  output logic [31:0] MemAdr,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Dout,
  output logic        AdEL,
  output logic        BusErr
);

  localparam logic [2:0] LD_LW   = 3'd0;
  localparam logic [2:0] LD_LH   = 3'd1;
  localparam logic [2:0] LD_LHU  = 3'd2;
  localparam logic [2:0] LD_LB   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LWL  = 3'd5;
  localparam logic [2:0] LD_LWR  = 3'd6;
  localparam logic [2:0] LD_NONE = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]       lane;
  logic [2:0]       ctrl;
  logic [31:0]      rt_old;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;
  logic             accept;
  logic             timeout;
  logic [31:0]      result;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;
  logic [4:0]       shl;
  logic [4:0]       shr;

  always_comb begin
    misaligned = 1'b0;
    case (LdCtrl)
      LD_LW:          misaligned = (Adr[1:0] != 2'b00);
      LD_LH, LD_LHU:  misaligned = Adr[0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign accept  = (state == S_IDLE) && Start && (LdCtrl != LD_NONE) && !misaligned;
  assign timeout = (cnt == CNT_LAST);
  assign Busy    = accept || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_WAIT;
      S_WAIT: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (MemAck)       state_nxt = S_DONE;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift amounts for the unaligned merges: 8*(3-b) and 8*b.
  assign shl = {~lane, 3'b000};
  assign shr = {lane, 3'b000};

  always_comb begin
    half_sel = lane[1] ? MemRData[31:16] : MemRData[15:0];
    byte_sel = MemRData[7:0];
    case (lane)
      2'd0:    byte_sel = MemRData[7:0];
      2'd1:    byte_sel = MemRData[15:8];
      2'd2:    byte_sel = MemRData[23:16];
      default: byte_sel = MemRData[31:24];
    endcase
    result = MemRData;
    case (ctrl)
      LD_LW:   result = MemRData;
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0000, half_sel};
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h000000, byte_sel};
      LD_LWL:  result = (MemRData << shl) | (rt_old & ((32'd1 << shl) - 32'd1));
      LD_LWR:  result = (MemRData >> shr) | (rt_old & ~(32'hFFFF_FFFF >> shr));
      default: result = MemRData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MemReq <= 1'b0;
      MemAdr <= 32'h0;
      Done   <= 1'b0;
      AdEL   <= 1'b0;
      BusErr <= 1'b0;
      Dout   <= 32'h0;
      cnt    <= '0;
      lane   <= 2'b00;
      ctrl   <= LD_NONE;
      rt_old <= 32'h0;
    end else begin
      Done   <= 1'b0;
      AdEL   <= 1'b0;
      BusErr <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (Start && (LdCtrl != LD_NONE) && misaligned) AdEL <= 1'b1;
          if (accept) begin
            MemReq <= 1'b1;
            MemAdr <= {Adr[31:2], 2'b00};
            lane   <= Adr[1:0];
            ctrl   <= LdCtrl;
            rt_old <= RtOld;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (MemAck) begin
            Dout   <= result;
            Done   <= 1'b1;
            MemReq <= 1'b0;
          end else if (timeout) begin
            BusErr <= 1'b1;
            MemReq <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
